// File: rtl/instruction_sequencer.sv
// Program buffer and issue sequencer feeding core: issues one instruction per start/busy
// handshake and flags a core that never acknowledges with busy.
module instruction_sequencer #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int DEPTH             = 64,
    parameter int ADDR_WIDTH        = 6,
    parameter int ACK_TIMEOUT       = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_en,
    input  logic [ADDR_WIDTH-1:0]        load_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] load_data,
    input  logic [ADDR_WIDTH:0]          length,
    input  logic                         run,
    input  logic                         busy,
    output logic [INSTRUCTION_WIDTH-1:0] instructionOut,
    output logic                         coreStart,
    output logic [ADDR_WIDTH-1:0]        pc,
    output logic                         running,
    output logic                         done,
    output logic                         error
);

    localparam int                TW         = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0]     L_TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0] L_DEPTH  = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [INSTRUCTION_WIDTH-1:0]   r_mem [DEPTH];
    logic [INSTRUCTION_WIDTH-1:0]   r_instr;
    logic [ADDR_WIDTH-1:0]          r_pc;
    logic [ADDR_WIDTH:0]            r_len;
    logic [TW-1:0]                  r_timer;
    logic                           r_error;

    logic [ADDR_WIDTH-1:0]          w_pc_inc;
    logic [TW-1:0]                  w_timer_inc;
    logic [ADDR_WIDTH:0]            w_len_clamped;
    logic                           w_start_prog;
    logic                           w_last;
    logic                           w_timeout;
    logic                           w_advance;

    assign w_pc_inc      = r_pc + ADDR_WIDTH'(1);
    assign w_timer_inc   = r_timer + TW'(1);
    assign w_len_clamped = (length > L_DEPTH) ? L_DEPTH : length;
    assign w_last        = ({1'b0, r_pc} == (r_len - (ADDR_WIDTH + 1)'(1)));
    // Timeout fires on the cycle the incremented count would reach ACK_TIMEOUT-1,
    // so error lands ACK_TIMEOUT cycles after the ISSUE cycle.
    assign w_timeout     = (r_state == S_WAIT_ACK) && !busy && (w_timer_inc == L_TMO_LAST);
    assign w_advance     = (r_state == S_WAIT_DONE) && !busy && !w_last;
    assign w_start_prog  = (r_state == S_IDLE) && run && (length != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (run) w_state_next = (length != '0) ? S_ISSUE : S_DONE;
            S_ISSUE:     w_state_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (busy)           w_state_next = S_WAIT_DONE;
                else if (w_timeout) w_state_next = S_IDLE;
            end
            S_WAIT_DONE: if (!busy) w_state_next = w_last ? S_DONE : S_ISSUE;
            S_DONE:      w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Buffer survives reset; run wins over a same-cycle load.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && load_en && !run) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_len   <= '0;
            r_timer <= '0;
            r_error <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && run) begin
                r_error <= 1'b0;
            end
            if (w_start_prog) begin
                r_len   <= w_len_clamped;
                r_pc    <= '0;
                r_instr <= r_mem[0];
            end
            if (r_state == S_ISSUE) begin
                r_timer <= '0;
            end
            if ((r_state == S_WAIT_ACK) && !busy) begin
                r_timer <= w_timer_inc;
                if (w_timeout) begin
                    r_error <= 1'b1;
                end
            end
            if (w_advance) begin
                r_pc    <= w_pc_inc;
                r_instr <= r_mem[w_pc_inc];
            end
        end
    end

    assign instructionOut = r_instr;
    assign coreStart      = (r_state == S_ISSUE);
    assign pc             = r_pc;
    assign running        = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign error          = r_error;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with a behavioural core busy responder.
module tb_instruction_sequencer;

    localparam int IW    = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int TMO   = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic [AW:0]   length = '0;
    logic          run = 1'b0;
    logic          busy = 1'b0;
    logic [IW-1:0] instructionOut;
    logic          coreStart;
    logic [AW-1:0] pc;
    logic          running;
    logic          done;
    logic          error;

    instruction_sequencer #(
        .INSTRUCTION_WIDTH (IW),
        .DEPTH             (DEPTH),
        .ADDR_WIDTH        (AW),
        .ACK_TIMEOUT       (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .length         (length),
        .run            (run),
        .busy           (busy),
        .instructionOut (instructionOut),
        .coreStart      (coreStart),
        .pc             (pc),
        .running        (running),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: busy high for 4 cycles starting one cycle after coreStart.
    bit busy_auto = 1'b1;
    int busy_cnt  = 0;
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
            busy     = 1'b0;
        end else begin
            if (busy_cnt > 0) begin
                busy     = 1'b1;
                busy_cnt = busy_cnt - 1;
            end else begin
                busy = 1'b0;
            end
            if (busy_auto && coreStart) busy_cnt = 4;
        end
    end

    int            n_start = 0;
    int            n_done  = 0;
    int            n_run   = 0;
    int            last_done_cyc = 0;
    logic [AW-1:0] st_pc    [256];
    logic [IW-1:0] st_instr [256];
    int            st_cyc   [256];
    always @(negedge clk) begin
        if (coreStart && n_start < 256) begin
            st_pc[n_start]    = pc;
            st_instr[n_start] = instructionOut;
            st_cyc[n_start]   = cyc;
            n_start           = n_start + 1;
        end
        if (done) begin
            n_done        = n_done + 1;
            last_done_cyc = cyc;
        end
        if (running) n_run = n_run + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick(1);
        load_en   = 1'b0;
    endtask

    task automatic start_run(input logic [AW:0] len);
        run    = 1'b1;
        length = len;
        tick(1);
        run    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick(1);
            if (done) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_instr"},   64'(instructionOut), 64'd0);
        check({pfx, "_start"},   64'(coreStart),      64'd0);
        check({pfx, "_pc"},      64'(pc),             64'd0);
        check({pfx, "_running"}, 64'(running),        64'd0);
        check({pfx, "_done"},    64'(done),           64'd0);
        check({pfx, "_error"},   64'(error),          64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [IW-1:0] prog [3];
    int b_s, b_d, b_r;

    initial begin
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h0030_8113;
        prog[2] = 32'h0020_81B3;

        #1 reset = 1'b1;
        tick(1);
        check_reset_vals("rst");
        reset = 1'b0;
        tick(1);

        // Three-instruction program
        for (int i = 0; i < 3; i++) load(AW'(i), prog[i]);
        b_s = n_start;
        b_d = n_done;
        start_run(7'd3);
        check("t1_start_next_cycle", 64'(coreStart), 64'd1);
        check("t1_running",          64'(running),   64'd1);
        wait_done("t1_done_seen", 200);
        check("t1_running_in_done", 64'(running), 64'd1);
        tick(1);
        check("t1_running_drop", 64'(running), 64'd0);
        tick(1);
        check("t1_starts", 64'(n_start - b_s), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_pc%0d", i),    64'(st_pc[b_s + i]),    64'(i));
            check($sformatf("t1_instr%0d", i), 64'(st_instr[b_s + i]), 64'(prog[i]));
        end
        check("t1_gap01", 64'(st_cyc[b_s + 1] - st_cyc[b_s]),     64'd6);
        check("t1_gap12", 64'(st_cyc[b_s + 2] - st_cyc[b_s + 1]), 64'd6);
        check("t1_done_lat", 64'(last_done_cyc - st_cyc[b_s + 2]), 64'd6);
        check("t1_done_count", 64'(n_done - b_d), 64'd1);
        check("t1_error", 64'(error), 64'd0);

        // Zero-length program
        b_s = n_start;
        b_d = n_done;
        b_r = n_run;
        start_run(7'd0);
        check("t2_done",     64'(done),      64'd1);
        check("t2_no_start", 64'(coreStart), 64'd0);
        tick(1);
        check("t2_done_low",    64'(done),    64'd0);
        check("t2_running_low", 64'(running), 64'd0);
        tick(1);
        check("t2_starts",       64'(n_start - b_s), 64'd0);
        check("t2_running_cyc",  64'(n_run - b_r),   64'd1);
        check("t2_done_count",   64'(n_done - b_d),  64'd1);

        // Acknowledge timeout
        busy_auto = 1'b0;
        b_s = n_start;
        b_d = n_done;
        start_run(7'd2);
        check("t3_issue", 64'(coreStart), 64'd1);
        tick(7);
        check("t3_err_not_yet",  64'(error),   64'd0);
        check("t3_still_run",    64'(running), 64'd1);
        tick(1);
        check("t3_err_set",      64'(error),   64'd1);
        check("t3_idle",         64'(running), 64'd0);
        check("t3_no_done_now",  64'(done),    64'd0);
        tick(3);
        check("t3_starts",     64'(n_start - b_s), 64'd1);
        check("t3_done_count", 64'(n_done - b_d),  64'd0);
        check("t3_err_sticky", 64'(error),         64'd1);
        busy_auto = 1'b1;
        start_run(7'd1);
        check("t3_err_cleared", 64'(error), 64'd0);
        wait_done("t3_rerun_done", 100);
        tick(2);

        // Load and run while running are ignored
        b_s = n_start;
        start_run(7'd3);
        run       = 1'b1;
        length    = 7'd1;
        load_en   = 1'b1;
        load_addr = '0;
        load_data = '1;
        tick(1);
        run     = 1'b0;
        load_en = 1'b0;
        wait_done("t4_done", 200);
        tick(2);
        check("t4_starts", 64'(n_start - b_s), 64'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("t4_instr%0d", i), 64'(st_instr[b_s + i]), 64'(prog[i]));
        // run and load together in IDLE: run wins
        run       = 1'b1;
        length    = 7'd2;
        load_en   = 1'b1;
        load_addr = '0;
        load_data = '1;
        tick(1);
        run     = 1'b0;
        load_en = 1'b0;
        check("t4_combo_start", 64'(coreStart),      64'd1);
        check("t4_combo_instr", 64'(instructionOut), 64'(prog[0]));
        wait_done("t4_combo_done", 200);
        tick(2);
        start_run(7'd1);
        check("t4_entry0_kept", 64'(instructionOut), 64'(prog[0]));
        wait_done("t4_kept_done", 100);
        tick(2);

        // Reset during WAIT_DONE of the second instruction
        start_run(7'd3);
        for (int k = 0; k < 100 && !(coreStart && pc == 6'd1); k++) tick(1);
        check("t5_reach_pc1", 64'(coreStart && pc == 6'd1), 64'd1);
        tick(3);
        check("t5_mid_running", 64'(running), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_vals("t5_async");
        tick(1);
        reset = 1'b0;
        tick(6);
        b_s = n_start;
        start_run(7'd3);
        check("t5_rerun_pc",    64'(pc),             64'd0);
        check("t5_rerun_instr", 64'(instructionOut), 64'(prog[0]));
        wait_done("t5_rerun_done", 200);
        tick(2);
        check("t5_rerun_starts", 64'(n_start - b_s), 64'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("t5_rerun_w%0d", i), 64'(st_instr[b_s + i]), 64'(prog[i]));

        // Length beyond DEPTH clamps to DEPTH
        for (int i = 0; i < DEPTH; i++) load(AW'(i), 32'hA000_0000 | 32'(i));
        b_s = n_start;
        b_d = n_done;
        start_run(7'(DEPTH + 5));
        wait_done("t6_done", 1000);
        check("t6_pc_at_done", 64'(pc), 64'(DEPTH - 1));
        tick(2);
        check("t6_pc_held",    64'(pc),             64'(DEPTH - 1));
        check("t6_starts",     64'(n_start - b_s),  64'(DEPTH));
        check("t6_done_count", 64'(n_done - b_d),   64'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("t6_pc%0d", i),    64'(st_pc[b_s + i]),    64'(i));
            check($sformatf("t6_instr%0d", i), 64'(st_instr[b_s + i]), 64'(32'hA000_0000 | 32'(i)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
